spi_host_tlul: RTL

SPI_HOST_TLUL -- requirements
Module: spi_host_tlul

---
 rtl/spi_host_tlul.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_host_tlul.sv
// TL-UL attached SPI host: one mode-0 transfer of 1..32 bits per TXDATA write.
// Registers: CTRL (clkdiv, nbits_m1, keep_cs), TXDATA, RXDATA, STATUS (busy, done W1C).

package tlul_pkg;
   localparam logic [2:0] PutFullData    = 3'h0;
   localparam logic [2:0] PutPartialData = 3'h1;
   localparam logic [2:0] Get            = 3'h4;
   localparam logic [2:0] AccessAck      = 3'h0;
   localparam logic [2:0] AccessAckData  = 3'h1;

   typedef struct packed {
      logic        a_valid;
      logic [2:0]  a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;
endpackage

module spi_host_tlul #(
   parameter logic [7:0] ClkDivReset = 8'd3
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  tlul_pkg::tl_h2d_t  tl_i,
   output tlul_pkg::tl_d2h_t  tl_o,
   output logic               spi_sclk_o,
   output logic               spi_cs_no,
   output logic               spi_sdo_o,
   input  logic               spi_sdi_i,
   output logic               irq_done_o
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StSetup = 2'd1;
   localparam logic [1:0] StShift = 2'd2;
   localparam logic [1:0] StHold  = 2'd3;

   localparam logic [7:0] AddrCtrl   = 8'h00;
   localparam logic [7:0] AddrTx     = 8'h04;
   localparam logic [7:0] AddrRx     = 8'h08;
   localparam logic [7:0] AddrStatus = 8'h0C;

   // Register file
   logic [7:0]  clkdiv_q;
   logic [4:0]  nbits_m1_q;
   logic        keep_cs_q;
   logic [31:0] rxdata_q;
   logic        done_q;

   // Transfer engine
   logic [1:0]  state_q;
   logic [7:0]  cnt_q;
   logic [7:0]  div_q;
   logic [4:0]  bit_cnt_q;
   logic        keep_q;
   logic [31:0] tx_sh_q;
   logic [31:0] rx_sh_q;
   logic        sclk_q, cs_n_q, sdo_q;

   // Response channel
   logic        rsp_valid_q, rsp_error_q;
   logic [2:0]  rsp_opcode_q;
   logic [1:0]  rsp_size_q;
   logic [7:0]  rsp_source_q;
   logic [31:0] rsp_data_q;

   logic        a_ready, a_fire, is_get, busy, req_err, wr_ok;
   logic        ctrl_we, tx_we, status_we, done_set;
   logic [7:0]  addr;
   logic [31:0] wmask, wdata, ctrl_rd, ctrl_new, rdata;
   logic        unused_tl;

   assign unused_tl = ^{tl_i.a_param, tl_i.a_address[31:8]};

   // Request decode, error classification and read mux
   always_comb begin
      a_ready   = !(rsp_valid_q && !tl_i.d_ready);
      a_fire    = tl_i.a_valid && a_ready;
      is_get    = (tl_i.a_opcode == tlul_pkg::Get);
      addr      = tl_i.a_address[7:0];
      busy      = (state_q != StIdle);
      wmask     = {{8{tl_i.a_mask[3]}}, {8{tl_i.a_mask[2]}},
                   {8{tl_i.a_mask[1]}}, {8{tl_i.a_mask[0]}}};
      wdata     = tl_i.a_data & wmask;
      ctrl_rd   = {15'b0, keep_cs_q, 3'b0, nbits_m1_q, clkdiv_q};
      ctrl_new  = (ctrl_rd & ~wmask) | wdata;
      req_err   = !(addr inside {AddrCtrl, AddrTx, AddrRx, AddrStatus}) ||
                  (tl_i.a_size != 2'd2) ||
                  (!is_get && addr == AddrTx && busy);
      wr_ok     = a_fire && !is_get && !req_err;
      ctrl_we   = wr_ok && (addr == AddrCtrl);
      tx_we     = wr_ok && (addr == AddrTx);
      status_we = wr_ok && (addr == AddrStatus);
      done_set  = (state_q == StHold) && (cnt_q == 8'd0);
      case (addr)
         AddrCtrl:   rdata = ctrl_rd;
         AddrRx:     rdata = rxdata_q;
         AddrStatus: rdata = {30'b0, done_q, busy};
         default:    rdata = 32'b0;
      endcase
   end

   // Single-entry response register; a new request may be accepted as the old one drains
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rsp_valid_q  <= 1'b0;
         rsp_error_q  <= 1'b0;
         rsp_opcode_q <= 3'b0;
         rsp_size_q   <= 2'b0;
         rsp_source_q <= 8'b0;
         rsp_data_q   <= 32'b0;
      end else if (a_fire) begin
         rsp_valid_q  <= 1'b1;
         rsp_error_q  <= req_err;
         rsp_opcode_q <= is_get ? tlul_pkg::AccessAckData : tlul_pkg::AccessAck;
         rsp_size_q   <= tl_i.a_size;
         rsp_source_q <= tl_i.a_source;
         rsp_data_q   <= (is_get && !req_err) ? rdata : 32'b0;
      end else if (tl_i.d_ready) begin
         rsp_valid_q  <= 1'b0;
      end
   end

   // CTRL register and done flag (hardware set beats W1C)
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         clkdiv_q   <= ClkDivReset;
         nbits_m1_q <= 5'd31;
         keep_cs_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         if (ctrl_we) begin
            clkdiv_q   <= ctrl_new[7:0];
            nbits_m1_q <= ctrl_new[12:8];
            keep_cs_q  <= ctrl_new[16];
         end
         if (done_set) begin
            done_q <= 1'b1;
         end else if (status_we && wdata[1]) begin
            done_q <= 1'b0;
         end
      end
   end

   // Transfer FSM: SETUP (H), N x {sclk high H, sclk low H}, HOLD (H)
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         cnt_q     <= 8'd0;
         div_q     <= 8'd0;
         bit_cnt_q <= 5'd0;
         keep_q    <= 1'b0;
         tx_sh_q   <= 32'b0;
         rx_sh_q   <= 32'b0;
         rxdata_q  <= 32'b0;
         sclk_q    <= 1'b0;
         cs_n_q    <= 1'b1;
         sdo_q     <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (tx_we) begin
                  state_q   <= StSetup;
                  cnt_q     <= clkdiv_q;
                  div_q     <= clkdiv_q;
                  bit_cnt_q <= nbits_m1_q;
                  keep_q    <= keep_cs_q;
                  // Left-align so the current bit is always tx_sh_q[31]
                  tx_sh_q   <= wdata << (5'd31 - nbits_m1_q);
                  rx_sh_q   <= 32'b0;
                  sdo_q     <= wdata[nbits_m1_q];
                  cs_n_q    <= 1'b0;
                  sclk_q    <= 1'b0;
               end
            end
            StSetup: begin
               if (cnt_q != 8'd0) begin
                  cnt_q <= cnt_q - 8'd1;
               end else begin
                  state_q <= StShift;
                  cnt_q   <= div_q;
                  sclk_q  <= 1'b1;
                  rx_sh_q <= {rx_sh_q[30:0], spi_sdi_i};
               end
            end
            StShift: begin
               if (cnt_q != 8'd0) begin
                  cnt_q <= cnt_q - 8'd1;
               end else begin
                  cnt_q <= div_q;
                  if (sclk_q) begin
                     sclk_q <= 1'b0;
                     // Last bit stays on sdo through HOLD
                     if (bit_cnt_q != 5'd0) begin
                        tx_sh_q <= tx_sh_q << 1;
                        sdo_q   <= tx_sh_q[30];
                     end
                  end else if (bit_cnt_q == 5'd0) begin
                     state_q <= StHold;
                  end else begin
                     bit_cnt_q <= bit_cnt_q - 5'd1;
                     sclk_q    <= 1'b1;
                     rx_sh_q   <= {rx_sh_q[30:0], spi_sdi_i};
                  end
               end
            end
            default: begin
               if (cnt_q != 8'd0) begin
                  cnt_q <= cnt_q - 8'd1;
               end else begin
                  state_q  <= StIdle;
                  sdo_q    <= 1'b0;
                  cs_n_q   <= !keep_q;
                  rxdata_q <= rx_sh_q;
               end
            end
         endcase
      end
   end

   // Output mapping
   always_comb begin
      tl_o.d_valid  = rsp_valid_q;
      tl_o.d_opcode = rsp_opcode_q;
      tl_o.d_param  = 3'b0;
      tl_o.d_size   = rsp_size_q;
      tl_o.d_source = rsp_source_q;
      tl_o.d_sink   = 1'b0;
      tl_o.d_data   = rsp_data_q;
      tl_o.d_error  = rsp_error_q;
      tl_o.a_ready  = a_ready;
      spi_sclk_o    = sclk_q;
      spi_cs_no     = cs_n_q;
      spi_sdo_o     = sdo_q;
      irq_done_o    = done_q;
   end

endmodule
